// File: rtl/img_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_frame_reader_pkg
// Description : Shared types and constants for the image frame reader.
//               Contents:
//                 state_t       generator FSM state encoding
//                 beat_flags_t  per-beat framing bundle, pipelined beside
//                               the RAM read
//                 rows_t/cols_t/addr_t
//                               geometry types sized for the default
//                               640x480 single-tap frame
//                 RD_LATENCY    RAM read latency in cke beats
// Revision    : 1.0 - initial release
// ============================================================================
package img_frame_reader_pkg;

    // RAM read path: address register stage plus output register stage.
    localparam int RD_LATENCY = 2;

    localparam int DEF_ROWS_BITS = 9;
    localparam int DEF_COLS_BITS = 10;
    localparam int DEF_ADDR_BITS = 19;

    typedef logic [DEF_ROWS_BITS-1:0] rows_t;
    typedef logic [DEF_COLS_BITS-1:0] cols_t;
    typedef logic [DEF_ADDR_BITS-1:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_HBLANK = 3'd2,
        ST_VBLANK = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic valid;
        logic de;
        logic row_first;
        logic row_last;
        logic col_first;
        logic col_last;
        logic frame_start;
    } beat_flags_t;

endpackage
`default_nettype wire

// File: rtl/img_frame_reader_timing.sv
`default_nettype none
// ============================================================================
// Module      : img_frame_reader_timing
// Description : Raster timing generator for the image frame reader.
//               Produces one generator beat per cke with framing flags and
//               the linear RAM word address.
//               Ports:
//                 reset/clk/cke            async reset, clock, advance
//                 start/param_rows/cols    frame request and geometry
//                 busy                     frame in progress, incl. drain
//                 rows/cols                latched geometry
//                 addr                     RAM word address of this beat
//                 flags                    framing of this beat
//               Build option IMG_FRAME_READER_LOOP_EN: frames repeat
//               back-to-back, geometry re-latched at each frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module img_frame_reader_timing
    import img_frame_reader_pkg::*;
#(
    parameter int ROWS_BITS = 9,
    parameter int COLS_BITS = 10,
    parameter int BUF_SIZE  = 640*480,
    parameter int ADDR_BITS = $clog2(BUF_SIZE),
    parameter int H_BLANK   = 16,
    parameter int V_BLANK   = 2
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,
    input  logic                 start,
    input  logic [ROWS_BITS-1:0] param_rows,
    input  logic [COLS_BITS-1:0] param_cols,
    output logic                 busy,
    output logic [ROWS_BITS-1:0] rows,
    output logic [COLS_BITS-1:0] cols,
    output logic [ADDR_BITS-1:0] addr,
    output beat_flags_t          flags
);

    localparam logic [ADDR_BITS-1:0] c_ADDR_LAST  = ADDR_BITS'(BUF_SIZE - 1);
    localparam logic [1:0]           c_DRAIN_LAST = 2'(RD_LATENCY - 1);

    state_t               r_state;
    logic [COLS_BITS-1:0] r_x;
    logic [ROWS_BITS-1:0] r_y;
    logic [31:0]          r_blk;
    logic [1:0]           r_drain;
    logic [ROWS_BITS-1:0] r_rows;
    logic [COLS_BITS-1:0] r_cols;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_busy;

    logic        w_params_ok;
    logic        w_x_last;
    logic        w_y_last;
    logic        w_h_last;
    logic        w_v_last;
    logic [31:0] w_vblank_len;
    logic        w_row_end;
    logic        w_frame_end;
    logic        w_accept;
    logic        w_reload;
    logic        w_in_row;

    assign w_params_ok  = (param_rows != '0) && (param_cols != '0);
    assign w_x_last     = (r_x == r_cols - 1'b1);
    assign w_y_last     = (r_y == r_rows - 1'b1);
    assign w_h_last     = (r_blk == 32'(H_BLANK - 1));
    assign w_vblank_len = 32'(V_BLANK) * (32'(r_cols) + 32'(H_BLANK));
    assign w_v_last     = (r_blk == w_vblank_len - 32'd1);

    // A row ends on its last active beat when there is no horizontal
    // blanking, otherwise on the last blanking beat.
    assign w_row_end   = ((r_state == ST_ACTIVE) && w_x_last && (H_BLANK == 0))
                      || ((r_state == ST_HBLANK) && w_h_last);
    assign w_frame_end = (w_row_end && w_y_last && (V_BLANK == 0))
                      || ((r_state == ST_VBLANK) && w_v_last);
    assign w_accept    = (r_state == ST_IDLE) && start && w_params_ok;

`ifdef IMG_FRAME_READER_LOOP_EN
    // Jump straight into the next frame so no idle beat appears on the
    // stream; the pipeline keeps flowing, so no drain is needed.
    assign w_reload = w_frame_end && w_params_ok;
`else
    assign w_reload = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_blk   <= '0;
            r_drain <= '0;
            r_rows  <= '0;
            r_cols  <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
        end else if (cke) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_busy <= 1'b1;
                end
                ST_ACTIVE: begin
                    r_addr <= (r_addr == c_ADDR_LAST) ? '0 : r_addr + 1'b1;
                    if (w_x_last) begin
                        r_x   <= '0;
                        r_blk <= '0;
                        if (H_BLANK > 0) r_state <= ST_HBLANK;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                ST_HBLANK: begin
                    if (!w_h_last) r_blk <= r_blk + 32'd1;
                end
                ST_VBLANK: begin
                    if (!w_v_last) r_blk <= r_blk + 32'd1;
                end
                ST_DONE: begin
                    if (r_drain == c_DRAIN_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Later assignments below take priority over the case above.
            if (w_row_end) begin
                r_blk <= '0;
                if (!w_y_last) begin
                    r_y     <= r_y + 1'b1;
                    r_state <= ST_ACTIVE;
                end else if (V_BLANK > 0) begin
                    r_state <= ST_VBLANK;
                end
            end

            if (w_frame_end) begin
                r_state <= ST_DONE;
                r_drain <= '0;
            end

            if (w_accept || w_reload) begin
                r_state <= ST_ACTIVE;
                r_rows  <= param_rows;
                r_cols  <= param_cols;
                r_x     <= '0;
                r_y     <= '0;
                r_blk   <= '0;
                r_addr  <= '0;
            end
        end
    end

    // Row flags stay up through the row's horizontal blanking; column flags
    // only exist on active beats.
    assign w_in_row = (r_state == ST_ACTIVE) || (r_state == ST_HBLANK);

    always_comb begin
        flags             = '0;
        flags.valid       = w_in_row || (r_state == ST_VBLANK);
        flags.de          = (r_state == ST_ACTIVE);
        flags.row_first   = w_in_row && (r_y == '0);
        flags.row_last    = w_in_row && w_y_last;
        flags.col_first   = flags.de && (r_x == '0);
        flags.col_last    = flags.de && w_x_last;
        flags.frame_start = flags.row_first && flags.col_first;
    end

    assign busy = r_busy;
    assign rows = r_rows;
    assign cols = r_cols;
    assign addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/jelly3_ram_simple_dualport.sv
`default_nettype none
// ============================================================================
// Module      : jelly3_ram_simple_dualport
// Description : Simple dual-port RAM. One write port and one read port.
//               The read port has a read-enable and an optional output
//               register with its own clock enable.
//               Ports:
//                 wr_clk/wr_en/wr_addr/wr_din   write port
//                 rd_clk/rd_en/rd_regcke        read port enables
//                 rd_addr/rd_dout               read address and data
//               A read and a write to the same address in the same cycle
//               return the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module jelly3_ram_simple_dualport #(
    parameter int    ADDR_BITS = 10,
    parameter int    DATA_BITS = 8,
    parameter int    MEM_DEPTH = 1024,
    parameter string RAM_TYPE  = "block",
    parameter bit    DOUT_REG  = 1'b1
) (
    input  logic                 wr_clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_din,
    input  logic                 rd_clk,
    input  logic                 rd_en,
    input  logic                 rd_regcke,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_dout
);

    logic [DATA_BITS-1:0] r_rd_data;

    // The array carries the implementation-style attribute for the vendor
    // tool; behaviour is the same in both branches.
    if (RAM_TYPE == "ultra") begin : g_ultra
        (* ram_style = "ultra" *) logic [DATA_BITS-1:0] mem [MEM_DEPTH];
        always_ff @(posedge wr_clk) begin
            if (wr_en) mem[wr_addr] <= wr_din;
        end
        always_ff @(posedge rd_clk) begin
            if (rd_en) r_rd_data <= mem[rd_addr];
        end
    end else begin : g_block
        (* ram_style = "block" *) logic [DATA_BITS-1:0] mem [MEM_DEPTH];
        always_ff @(posedge wr_clk) begin
            if (wr_en) mem[wr_addr] <= wr_din;
        end
        always_ff @(posedge rd_clk) begin
            if (rd_en) r_rd_data <= mem[rd_addr];
        end
    end

    if (DOUT_REG) begin : g_dout_reg
        logic [DATA_BITS-1:0] r_dout;
        always_ff @(posedge rd_clk) begin
            if (rd_regcke) r_dout <= r_rd_data;
        end
        assign rd_dout = r_dout;
    end else begin : g_dout_direct
        assign rd_dout = r_rd_data;
    end

endmodule
`default_nettype wire

// File: rtl/img_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : img_frame_reader
// Description : Frame-buffer reader. A host word port fills on-chip RAM; on
//               start the image is read back in raster order and emitted as
//               a mat stream with framing and blanking. Everything advances
//               on cke only.
//               Ports:
//                 reset/clk/cke                async reset, clock, advance
//                 start/param_rows/param_cols  frame request and geometry
//                 busy                         frame in progress
//                 wr_en/wr_addr/wr_din         host word write port
//                 m_*                          mat stream output
//               Build option IMG_FRAME_READER_LOOP_EN: continuous
//               back-to-back frames until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module img_frame_reader
    import img_frame_reader_pkg::*;
#(
    parameter int    TAPS      = 1,
    parameter int    CH_BITS   = 8,
    parameter int    CH_DEPTH  = 1,
    parameter int    USER_BITS = 1,
    parameter int    ROWS_BITS = 9,
    parameter int    COLS_BITS = 10,
    parameter int    BUF_SIZE  = 640*480/TAPS,
    parameter int    H_BLANK   = 16,
    parameter int    V_BLANK   = 2,
    parameter string RAM_TYPE  = "ultra",
    localparam int   c_ADDR_BITS = $clog2(BUF_SIZE),
    localparam int   c_DATA_BITS = TAPS * CH_DEPTH * CH_BITS
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   cke,
    input  logic                   start,
    input  logic [ROWS_BITS-1:0]   param_rows,
    input  logic [COLS_BITS-1:0]   param_cols,
    output logic                   busy,
    input  logic                   wr_en,
    input  logic [c_ADDR_BITS-1:0] wr_addr,
    input  logic [c_DATA_BITS-1:0] wr_din,
    output logic [ROWS_BITS-1:0]   m_rows,
    output logic [COLS_BITS-1:0]   m_cols,
    output logic                   m_row_first,
    output logic                   m_row_last,
    output logic                   m_col_first,
    output logic                   m_col_last,
    output logic                   m_de,
    output logic [c_DATA_BITS-1:0] m_data,
    output logic [USER_BITS-1:0]   m_user,
    output logic                   m_valid
);

    logic [ROWS_BITS-1:0]   w_rows;
    logic [COLS_BITS-1:0]   w_cols;
    logic [c_ADDR_BITS-1:0] w_addr;
    beat_flags_t            w_flags;

    img_frame_reader_timing #(
        .ROWS_BITS (ROWS_BITS),
        .COLS_BITS (COLS_BITS),
        .BUF_SIZE  (BUF_SIZE),
        .ADDR_BITS (c_ADDR_BITS),
        .H_BLANK   (H_BLANK),
        .V_BLANK   (V_BLANK)
    ) u_timing (
        .reset      (reset),
        .clk        (clk),
        .cke        (cke),
        .start      (start),
        .param_rows (param_rows),
        .param_cols (param_cols),
        .busy       (busy),
        .rows       (w_rows),
        .cols       (w_cols),
        .addr       (w_addr),
        .flags      (w_flags)
    );

    jelly3_ram_simple_dualport #(
        .ADDR_BITS (c_ADDR_BITS),
        .DATA_BITS (c_DATA_BITS),
        .MEM_DEPTH (BUF_SIZE),
        .RAM_TYPE  (RAM_TYPE),
        .DOUT_REG  (1'b1)
    ) u_ram (
        .wr_clk    (clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_din    (wr_din),
        .rd_clk    (clk),
        .rd_en     (cke),
        .rd_regcke (cke),
        .rd_addr   (w_addr),
        .rd_dout   (m_data)
    );

    // Framing and geometry ride a two-stage delay so they line up with the
    // RAM data; geometry is delayed too so a re-latch in loop mode does not
    // change m_rows/m_cols under the tail of the previous frame.
    beat_flags_t          r_flags_d1, r_flags_d2;
    logic [ROWS_BITS-1:0] r_rows_d1,  r_rows_d2;
    logic [COLS_BITS-1:0] r_cols_d1,  r_cols_d2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags_d1 <= '0;
            r_flags_d2 <= '0;
            r_rows_d1  <= '0;
            r_rows_d2  <= '0;
            r_cols_d1  <= '0;
            r_cols_d2  <= '0;
        end else if (cke) begin
            r_flags_d1 <= w_flags;
            r_flags_d2 <= r_flags_d1;
            r_rows_d1  <= w_rows;
            r_rows_d2  <= r_rows_d1;
            r_cols_d1  <= w_cols;
            r_cols_d2  <= r_cols_d1;
        end
    end

    assign m_rows      = r_rows_d2;
    assign m_cols      = r_cols_d2;
    assign m_valid     = r_flags_d2.valid;
    assign m_de        = r_flags_d2.de;
    assign m_row_first = r_flags_d2.row_first;
    assign m_row_last  = r_flags_d2.row_last;
    assign m_col_first = r_flags_d2.col_first;
    assign m_col_last  = r_flags_d2.col_last;
    assign m_user      = USER_BITS'(r_flags_d2.frame_start);

endmodule
`default_nettype wire

// File: tb/tb_img_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_frame_reader
// Description : Self-checking bench for img_frame_reader. Three instances:
//                 0: H_BLANK=2, V_BLANK=1, BUF_SIZE=16
//                 1: H_BLANK=0, V_BLANK=0, BUF_SIZE=16
//                 2: H_BLANK=2, V_BLANK=1, BUF_SIZE=8 (address wrap)
//               With IMG_FRAME_READER_LOOP_EN the back-to-back frame
//               sequence is checked on instance 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_frame_reader;

    logic       clk;
    logic       reset;
    logic       cke;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_din;

    logic       start_i  [3];
    logic [8:0] prow     [3];
    logic [9:0] pcol     [3];
    logic       busy_o   [3];
    logic [8:0] rows_o   [3];
    logic [9:0] cols_o   [3];
    logic       rf_o     [3];
    logic       rl_o     [3];
    logic       cf_o     [3];
    logic       cl_o     [3];
    logic       de_o     [3];
    logic [7:0] data_o   [3];
    logic [0:0] user_o   [3];
    logic       valid_o  [3];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int HB = (gi == 1) ? 0 : 2;
        localparam int VB = (gi == 1) ? 0 : 1;
        localparam int BS = (gi == 2) ? 8 : 16;
        localparam int AW = (gi == 2) ? 3 : 4;

        img_frame_reader #(
            .TAPS      (1),
            .CH_BITS   (8),
            .CH_DEPTH  (1),
            .USER_BITS (1),
            .ROWS_BITS (9),
            .COLS_BITS (10),
            .BUF_SIZE  (BS),
            .H_BLANK   (HB),
            .V_BLANK   (VB),
            .RAM_TYPE  ("ultra")
        ) u_dut (
            .reset       (reset),
            .clk         (clk),
            .cke         (cke),
            .start       (start_i[gi]),
            .param_rows  (prow[gi]),
            .param_cols  (pcol[gi]),
            .busy        (busy_o[gi]),
            .wr_en       (wr_en && (32'(wr_addr) < BS)),
            .wr_addr     (wr_addr[AW-1:0]),
            .wr_din      (wr_din),
            .m_rows      (rows_o[gi]),
            .m_cols      (cols_o[gi]),
            .m_row_first (rf_o[gi]),
            .m_row_last  (rl_o[gi]),
            .m_col_first (cf_o[gi]),
            .m_col_last  (cl_o[gi]),
            .m_de        (de_o[gi]),
            .m_data      (data_o[gi]),
            .m_user      (user_o[gi]),
            .m_valid     (valid_o[gi])
        );
    end

    // Packed beat: {valid, de, row_first, row_last, col_first, col_last,
    // user0, 0, data}; data is only meaningful on de beats.
    function automatic logic [31:0] obs(input int i);
        return {16'h0, valid_o[i], de_o[i], rf_o[i], rl_o[i], cf_o[i], cl_o[i],
                user_o[i][0], 1'b0, (de_o[i] ? data_o[i] : 8'h00)};
    endfunction

    // Expected output beat k of a frame started from address 0 with RAM
    // word n holding n.
    function automatic logic [31:0] exp_beat(input int rows, input int cols,
                                             input int hb, input int vb,
                                             input int bufsz, input bit loop_mode,
                                             input int k);
        int line, frame, total, kk, r, c;
        logic v, de, rf, rl, cf, cl, us;
        logic [7:0] d;
        line  = cols + hb;
        frame = rows * line;
        total = frame + vb * line;
        kk    = loop_mode ? (k % total) : k;
        v = 1'b0; de = 1'b0; rf = 1'b0; rl = 1'b0; cf = 1'b0; cl = 1'b0; us = 1'b0;
        d = 8'h00;
        if (kk < frame) begin
            r  = kk / line;
            c  = kk % line;
            v  = 1'b1;
            de = (c < cols);
            rf = (r == 0);
            rl = (r == rows - 1);
            cf = de && (c == 0);
            cl = de && (c == cols - 1);
            us = rf && cf;
            d  = de ? 8'((r * cols + c) % bufsz) : 8'h00;
        end else if (kk < total) begin
            v = 1'b1;
        end
        return {16'h0, v, de, rf, rl, cf, cl, us, 1'b0, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cke_pat;
    int          n_cke;
    bit          t2_done;

    initial begin
        reset   = 1'b1;
        cke     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_din  = '0;
        for (int i = 0; i < 3; i++) begin
            start_i[i] = 1'b0;
            prow[i]    = '0;
            pcol[i]    = '0;
        end
        tick();
        tick();

        // Reset state of every instance
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_beat%0d", i), obs(i), 32'h0);
            check($sformatf("rst_busy%0d", i), 32'(busy_o[i]), 32'd0);
        end
        reset = 1'b0;
        tick();

        // Load word n = n (instance 2 takes only words 0..7)
        for (int a = 0; a < 16; a++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(a);
            wr_din  = 8'(a);
            tick();
        end
        wr_en = 1'b0;
        tick();

        // Zero geometry: start ignored
        start_i[0] = 1'b1;
        prow[0]    = 9'd0;
        pcol[0]    = 10'd4;
        tick();
        start_i[0] = 1'b0;
        tick();
        check("zero_rows_busy", 32'(busy_o[0]), 32'd0);
        check("zero_rows_valid", obs(0), 32'h0);

`ifdef IMG_FRAME_READER_LOOP_EN
        // Two back-to-back frames plus a few beats of the third
        prow[0] = 9'd3;
        pcol[0] = 10'd4;
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        tick();
        for (int k = 0; k < 54; k++) begin
            tick();
            check($sformatf("loop_beat%0d", k), obs(0), exp_beat(3, 4, 2, 1, 16, 1'b1, k));
            check($sformatf("loop_busy%0d", k), 32'(busy_o[0]), 32'd1);
        end
        reset = 1'b1;
        #1;
        check("loop_rst_valid", obs(0), 32'h0);
        check("loop_rst_busy", 32'(busy_o[0]), 32'd0);
        tick();
        reset = 1'b0;
        tick();
`else
        // Test 1: 3x4 frame, full speed, start retrigger ignored while busy
        prow[0] = 9'd3;
        pcol[0] = 10'd4;
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        check("t1_busy_rise", 32'(busy_o[0]), 32'd1);
        check("t1_lat0", obs(0), 32'h0);
        tick();
        check("t1_lat1", obs(0), 32'h0);
        for (int k = 0; k < 24; k++) begin
            if (k == 10) begin
                start_i[0] = 1'b1;
                prow[0]    = 9'd1;
                pcol[0]    = 10'd1;
            end
            if (k == 11) start_i[0] = 1'b0;
            tick();
            check($sformatf("t1_beat%0d", k), obs(0), exp_beat(3, 4, 2, 1, 16, 1'b0, k));
            if (k == 0) begin
                check("t1_rows", 32'(rows_o[0]), 32'd3);
                check("t1_cols", 32'(cols_o[0]), 32'd4);
            end
        end
        check("t1_busy_last", 32'(busy_o[0]), 32'd1);
        tick();
        check("t1_after_valid", obs(0), 32'h0);
        check("t1_after_busy", 32'(busy_o[0]), 32'd0);
        tick();

        // Test 2: same frame under a stall pattern
        prow[0] = 9'd3;
        pcol[0] = 10'd4;
        cke_pat = 32'b1011_0010_1110_0101_1001_1101_0100_1101;
        cke = 1'b1;
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        n_cke   = 1;
        t2_done = 1'b0;
        for (int s = 0; s < 200 && !t2_done; s++) begin
            cke = cke_pat[s % 32];
            tick();
            if (cke) n_cke++;
            if (n_cke - 3 == 24) begin
                check("t2_after_valid", obs(0), 32'h0);
                check("t2_after_busy", 32'(busy_o[0]), 32'd0);
                t2_done = 1'b1;
            end else if (n_cke >= 3) begin
                check($sformatf("t2_step%0d_beat%0d", s, n_cke - 3), obs(0),
                      exp_beat(3, 4, 2, 1, 16, 1'b0, n_cke - 3));
            end
        end
        if (!t2_done) check("t2_timeout", 32'(n_cke), 32'd27);
        cke = 1'b1;
        tick();

        // Test 3: reset on the 5th de beat, then replay from word 0
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) tick();
        check("t3_beat6", obs(0), exp_beat(3, 4, 2, 1, 16, 1'b0, 6));
        reset = 1'b1;
        #1;
        check("t3_async_valid", obs(0), 32'h0);
        check("t3_async_busy", 32'(busy_o[0]), 32'd0);
        tick();
        check("t3_edge_valid", obs(0), 32'h0);
        check("t3_edge_busy", 32'(busy_o[0]), 32'd0);
        reset = 1'b0;
        tick();
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        tick();
        for (int k = 0; k < 24; k++) begin
            tick();
            if (k < 8)
                check($sformatf("t3_replay%0d", k), obs(0), exp_beat(3, 4, 2, 1, 16, 1'b0, k));
        end
        tick();
        check("t3_end_busy", 32'(busy_o[0]), 32'd0);

        // Test 4: no blanking, 2x2
        prow[1] = 9'd2;
        pcol[1] = 10'd2;
        start_i[1] = 1'b1;
        tick();
        start_i[1] = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t4_beat%0d", k), obs(1), exp_beat(2, 2, 0, 0, 16, 1'b0, k));
            if (k == 0) begin
                check("t4_rows", 32'(rows_o[1]), 32'd2);
                check("t4_cols", 32'(cols_o[1]), 32'd2);
            end
        end
        tick();
        check("t4_after_valid", obs(1), 32'h0);
        check("t4_after_busy", 32'(busy_o[1]), 32'd0);

        // Test 5: 3x4 frame through an 8-word buffer (address wrap)
        prow[2] = 9'd3;
        pcol[2] = 10'd4;
        start_i[2] = 1'b1;
        tick();
        start_i[2] = 1'b0;
        tick();
        for (int k = 0; k < 24; k++) begin
            tick();
            check($sformatf("t5_beat%0d", k), obs(2), exp_beat(3, 4, 2, 1, 8, 1'b0, k));
            if (k == 0) begin
                check("t5_rows", 32'(rows_o[2]), 32'd3);
                check("t5_cols", 32'(cols_o[2]), 32'd4);
            end
        end
        tick();
        check("t5_after_valid", obs(2), 32'h0);
        check("t5_after_busy", 32'(busy_o[2]), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/img_frame_reader.md
Name: img_frame_reader

Overview:
- Transmitter counterpart of the frame-buffer writer path: a host-side word write port loads an image into on-chip RAM.
- On `start`, the block reads the image back in raster order and emits it as a jelly3 mat stream, framing included, toward downstream image pipelines (test-pattern / replay source for the optical-flow chain).
- All stages advance only on `cke`, mirroring mat-interface stall semantics.

Parameters:
- `TAPS`, 1, pixels per mat beat (one RAM word = `TAPS` pixels)
- `CH_BITS`, 8, bits per channel
- `CH_DEPTH`, 1, channels per pixel
- `USER_BITS`, 1, width of `m_user`
- `ROWS_BITS`, 9, width of row geometry
- `COLS_BITS`, 10, width of column geometry
- `BUF_SIZE`, 640*480/TAPS, RAM depth in words
- `H_BLANK`, 16, blanking beats appended after each row (0 allowed)
- `V_BLANK`, 2, blanking rows-worth of beats after frame; beats = `V_BLANK` * (cols + `H_BLANK`)
- `RAM_TYPE`, "ultra", passed to RAM

Ports:
- `reset`  in  1  asynchronous, active-high
- `clk`  in  1  single clock for everything
- `cke`  in  1  stream advance enable (downstream ready); 0 freezes all pipeline/FSM state
- `start`  in  1  pulse or level; sampled in IDLE only
- `param_rows`  in  ROWS_BITS  frame height, latched at start
- `param_cols`  in  COLS_BITS  frame width in beats, latched at start
- `busy`  out  1  high from accepted start until last output beat leaves
- `wr_en`  in  1  host word write
- `wr_addr`  in  $clog2(BUF_SIZE)  word address
- `wr_din`  in  TAPS*CH_DEPTH*CH_BITS  word data
- `m_rows`, `m_cols`  out  ROWS_BITS/COLS_BITS  latched geometry
- `m_row_first`, `m_row_last`, `m_col_first`, `m_col_last`  out  1 each  framing
- `m_de`  out  1  active pixel beat
- `m_data`  out  TAPS*CH_DEPTH*CH_BITS  pixel word
- `m_user`  out  USER_BITS  bit0 = frame start marker, others 0
- `m_valid`  out  1  beat valid

Behaviour:
- Reset (async, any time, including mid-frame): FSM→IDLE; `busy`, `m_valid`, `m_de`, all framing flags, `m_user` = 0; counters 0. RAM contents are not cleared (FILLMEM 0 at config).
- FSM states:
  - IDLE: `start` && `cke` → latch params, x=y=addr=0 → ACTIVE.
  - ACTIVE: one beat per cke, de=1, addr++; at x=cols-1 → HBLANK if `H_BLANK`>0, else next row.
  - HBLANK: de=0 beats; count `H_BLANK`; then y++. If y was rows-1 → VBLANK (or DONE if `V_BLANK`=0), else ACTIVE.
  - VBLANK: de=0 beats, count to `V_BLANK`*(cols+`H_BLANK`) → DONE.
  - DONE: wait pipeline drain (2 cke beats) → IDLE, `busy` falls.
- Generator stage emits valid=1 in ACTIVE/HBLANK/VBLANK. Flags:
  - `row_first` = (y==0), `row_last` = (y==rows-1), held across that row's HBLANK.
  - `col_first` = (x==0 && de), `col_last` = (x==cols-1 && de).
  - `user[0]` = row_first && col_first.
  - VBLANK beats: row flags and col flags all 0.
- Latency: RAM has DOUT_REG=1 → 2 cke beats; framing pipelined 2 stages to align. Output beat n corresponds to generator beat n-2 counted in cke cycles. RAM `rd_en`/`rd_regcke` = `cke`.
- Address: linear word counter incremented only on de beats; wraps BUF_SIZE-1→0. rows*cols > BUF_SIZE is legal (wraps, no error).
- Write port is independent of `cke`; writes allowed during playback. Same-cycle same-address read returns old data.
- `start` while busy: ignored. `param_rows` or `param_cols` = 0: start ignored, stay IDLE.

Optional Feature:
- `IMG_FRAME_READER_LOOP_EN`
- Defined: DONE → ACTIVE directly, re-latching params and addr=0; `busy` stays 1 and frames repeat back-to-back with no idle beat; stop only by reset.
- Undefined: single-shot as above.

Decomposition:
- Package `img_frame_reader_pkg`: state enum (IDLE, ACTIVE, HBLANK, VBLANK, DONE), rows_t/cols_t/addr_t typedefs, latency constant `RD_LATENCY`=2.
- Sub-module `img_frame_reader_timing`: FSM + x/y/blank counters + flag generation. RAM is the existing `jelly3_ram_simple_dualport`.

Test Plan:
- Load words 0..11 with value=addr; rows=3, cols=4, H_BLANK=2, V_BLANK=1, cke=1 → 18 beats valid frame + 6 VBLANK beats; de beats carry 0..11 in order; first de 3 cycles after start (IDLE accept + 2 RAM latency); `user[0]` only on data 0; `busy` falls after last beat.
- Same frame, cke toggled 1,0 pseudo-randomly → identical output sequence on cke=1 cycles; outputs stable while cke=0.
- Reset asserted on 5th de beat → next edge `m_valid`=0, `busy`=0; subsequent start replays from data 0.
- H_BLANK=0, V_BLANK=0, rows=2, cols=2 → 4 contiguous de beats; col_last and row_last both high only on beat 3.
- BUF_SIZE=8, rows=3, cols=4 → data sequence 0..7,0..3 (wrap).
- With `IMG_FRAME_READER_LOOP_EN`, two frames → second frame's `user[0]` beat immediately follows the last VBLANK beat; `busy` stays 1.
